// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the SRAM arbiter: FSM state encoding and requester ids.
// No ports.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles both requester handshakes and the SRAM-side bus of mem_arbiter.
// Modports:
//   master : arbiter side (drives acks, rdata, err, busy, mem_en/rw/addr/data)
//   slave  : requesters + SRAM side (drives req*_*, mem_r, mem_out)
// Signals:
//   req0_valid/rw/addr/wdata  requester 0 (CPU) request fields
//   req0_ack/rdata            requester 0 completion pulse and read data
//   req1_*                    same set for requester 1 (DMA/display)
//   err                       timeout flag, qualified by an ack
//   busy                      arbiter not idle
//   mem_en/rw/addr/data       SRAM access strobe and fields
//   mem_r/mem_out             SRAM ready flag and read data
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_rw;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ack;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_rw;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ack;
    logic [DATA_W-1:0] req1_rdata;

    logic              err;
    logic              busy;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_r;
    logic [DATA_W-1:0] mem_out;

    modport master (
        input  req0_valid, req0_rw, req0_addr, req0_wdata,
        input  req1_valid, req1_rw, req1_addr, req1_wdata,
        input  mem_r, mem_out,
        output req0_ack, req0_rdata, req1_ack, req1_rdata,
        output err, busy, mem_en, mem_rw, mem_addr, mem_data
    );

    modport slave (
        output req0_valid, req0_rw, req0_addr, req0_wdata,
        output req1_valid, req1_rw, req1_addr, req1_wdata,
        output mem_r, mem_out,
        input  req0_ack, req0_rdata, req1_ack, req1_rdata,
        input  err, busy, mem_en, mem_rw, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant selection between the two requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, requester 0 wins a tie
//   defined   : on a tie, the requester that did not win last time wins
// Ports:
//   i_valid0, i_valid1  request valids
//   i_rr_last           id of the most recent grant
//   o_gnt_id            selected requester (meaningful when o_gnt_any=1)
//   o_gnt_any           at least one request pending
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    i_valid0,
    input  logic    i_valid1,
    input  req_id_t i_rr_last,
    output req_id_t o_gnt_id,
    output logic    o_gnt_any
);

    req_id_t w_tie_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign w_tie_id = (i_rr_last == REQ_CPU) ? REQ_DMA : REQ_CPU;
`else
    // Fixed priority never looks at the grant history.
    logic w_unused_rr;
    assign w_unused_rr = i_rr_last;
    assign w_tie_id    = REQ_CPU;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_gnt_any = i_valid0 | i_valid1;
        o_gnt_id  = REQ_CPU;
        if (i_valid0 && i_valid1) begin
            o_gnt_id = w_tie_id;
        end else if (i_valid1) begin
            o_gnt_id = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port SRAM between requester 0 (CPU) and requester 1
// (DMA/display). One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// ISSUE pulses mem_en for one cycle, WAIT holds the fields until the SRAM
// ready flag (or a WAIT_MAX-cycle timeout), DONE pulses the winner's ack.
// Build option: MEM_ARB_ROUND_ROBIN_EN (tie-break mode, see mem_arb_pick).
// Parameters: ADDR_W, DATA_W, WAIT_MAX (WAIT cycles before timeout, >=1)
// Ports:
//   clk      system clock, posedge
//   rst      synchronous active-high reset
//   arb_bus  mem_arbiter_if.master: requester handshakes, err/busy, SRAM bus
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master arb_bus
);

    localparam int TMR_W = $clog2(WAIT_MAX + 1);

    state_t            r_state;
    req_id_t           r_gnt_id;
    req_id_t           r_rr_last;
    logic [TMR_W-1:0]  r_timer;
    logic              r_mem_en;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_err;
    logic              r_busy;

    req_id_t           w_gnt_id;
    logic              w_gnt_any;
    logic [TMR_W-1:0]  w_timer_inc;

    mem_arb_pick u_pick (
        .i_valid0  (arb_bus.req0_valid),
        .i_valid1  (arb_bus.req1_valid),
        .i_rr_last (r_rr_last),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_any (w_gnt_any)
    );

    assign w_timer_inc = r_timer + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt_id   <= REQ_CPU;
            r_rr_last  <= REQ_DMA;   // so requester 0 wins the first tie
            r_timer    <= '0;
            r_mem_en   <= 1'b0;
            r_mem_rw   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            r_mem_en <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_state   <= ISSUE;
                        r_busy    <= 1'b1;
                        r_mem_en  <= 1'b1;
                        r_gnt_id  <= w_gnt_id;
                        r_rr_last <= w_gnt_id;
                        if (w_gnt_id == REQ_DMA) begin
                            r_mem_rw   <= arb_bus.req1_rw;
                            r_mem_addr <= arb_bus.req1_addr;
                            r_mem_data <= arb_bus.req1_wdata;
                        end else begin
                            r_mem_rw   <= arb_bus.req0_rw;
                            r_mem_addr <= arb_bus.req0_addr;
                            r_mem_data <= arb_bus.req0_wdata;
                        end
                    end
                end

                ISSUE: begin
                    r_state <= WAIT;
                    r_timer <= '0;
                end

                WAIT: begin
                    if (arb_bus.mem_r) begin
                        if (!r_mem_rw) begin
                            if (r_gnt_id == REQ_DMA) r_rdata1 <= arb_bus.mem_out;
                            else                     r_rdata0 <= arb_bus.mem_out;
                        end
                        r_err   <= 1'b0;
                        r_state <= DONE;
                        r_ack0  <= (r_gnt_id == REQ_CPU);
                        r_ack1  <= (r_gnt_id == REQ_DMA);
                    end else begin
                        r_timer <= w_timer_inc;
                        // Timer counts completed WAIT cycles; give up after WAIT_MAX of them.
                        if (w_timer_inc == TMR_W'(WAIT_MAX)) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                            r_ack0  <= (r_gnt_id == REQ_CPU);
                            r_ack1  <= (r_gnt_id == REQ_DMA);
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign arb_bus.req0_ack   = r_ack0;
    assign arb_bus.req0_rdata = r_rdata0;
    assign arb_bus.req1_ack   = r_ack1;
    assign arb_bus.req1_rdata = r_rdata1;
    assign arb_bus.err        = r_err;
    assign arb_bus.busy       = r_busy;
    assign arb_bus.mem_en     = r_mem_en;
    assign arb_bus.mem_rw     = r_mem_rw;
    assign arb_bus.mem_addr   = r_mem_addr;
    assign arb_bus.mem_data   = r_mem_data;

endmodule
